pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 valid_in  input  1  the decode-stage slot holds a real instruction.
REQ-005 Aselect  input  32  one-hot rs source select of the decode-stage instruction.
REQ-006 Bselect  input  32  one-hot rt select of the decode-stage instruction.
REQ-007 Dselect  input  32  one-hot destination select of the decode-stage instruction, after the Imm mux.
REQ-008 Imm  input  1  the decode-stage instruction uses an immediate operand.
REQ-009 LW  input  1  the decode-stage instruction is a load.
REQ-010 SW  input  1  the decode-stage instruction is a store.
REQ-011 stall  output  1  hold PC and the fetch/decode register this cycle.
REQ-012 bubble  output  1  zero the control bits entering execute this cycle; always equal to stall.
REQ-013 fwdA  output  2  operand-A source: 00 register file, 01 stage-1 result, 10 stage-2 result, 11 stage-3 result.
REQ-014 fwdB  output  2  operand-B source; same encoding as fwdA.
REQ-015 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-016 The block SHALL keep three in-flight stage records, S1 (execute), S2 (memory) and S3 (writeback); each record holds dst[31:0], and S1 also holds lw.
REQ-017 Effective destination: dst_in = Dselect & ~32'h1, forced to 0 when SW=1 or valid_in=0, so that r0 and stores never create hazards.
REQ-018 B-use: the instruction reads rt when valid_in=1 and (Imm=0 or SW=1); A-use: the instruction reads rs when valid_in=1.
REQ-019 Match is defined as matchX(src) = |(src & SX.dst & ~32'h1), a bitwise AND so that zero or multi-hot inputs are still defined.
REQ-020 The load-use stall SHALL be combinational: stall = S1.lw & ((A-use & match1(Aselect)) | (B-use & match1(Bselect))).
REQ-021 fwdA priority SHALL be newest first: A-use & match1 & ~S1.lw -> 01; else match2 -> 10; else match3 -> 11; else 00.
REQ-022 fwdB SHALL use the same priority as fwdA, gated by B-use.
REQ-023 fwdA and fwdB SHALL be 00 whenever stall=1.
REQ-024 Each clock edge, stage records SHALL update as follows:
- S3 <= S2 and S2 <= S1, unconditionally.
- S1 <= {dst_in, LW & valid_in} when stall=0.
- S1 <= {0, 0} (bubble) when stall=1.
REQ-025 A load-use stall SHALL last exactly 1 cycle: after the bubble S1.lw=0, so the next cycle resolves through the 10 forward path.
REQ-026 Back-to-back loads to the same register SHALL each stall independently with no extra penalty.
REQ-027 stall_cnt SHALL increment on every edge where stall=1 and hold at 16'hFFFF.
REQ-028 stall, bubble, fwdA and fwdB SHALL be combinational from inputs and state, with 0-cycle latency; stall_cnt is registered with 1-cycle latency.

Reset
REQ-029 While rst=1, all stage records and stall_cnt SHALL be 0, asynchronously, including mid-stall.
REQ-030 With the state cleared, outputs SHALL be stall=0, bubble=0, fwdA=00, fwdB=00, stall_cnt=0.
REQ-031 The first edge after rst deasserts SHALL capture the decode-stage inputs normally.

Verification
REQ-032 Load-use: LW with Dselect bit5, then add with Aselect bit5 -> stall=1 for 1 cycle, stall_cnt=1, then fwdA=10.
REQ-033 ALU chain: add D=bit3, then sub A=bit3 B=bit3 -> no stall, fwdA=01 and fwdB=01; one cycle later an instruction reading bit3 -> 10; next cycle -> 11.
REQ-034 r0 and store: LW D=bit0 then a consumer of bit0 -> no stall, fwd=00; SW with Bselect bit7 -> no later instruction sees a hazard on bit7.
REQ-035 Imm gating: LW D=bit4, then an addi with Bselect=bit4 (its destination) and Aselect=bit2 -> no stall.
REQ-036 Saturation and reset: force 65536 load-use stalls -> stall_cnt holds FFFF; assert rst during a stall -> stall=0 and stall_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall and operand forwarding control for a 3-stage-deep in-flight window
// (execute, memory, writeback) using one-hot register selects.
`timescale 1ns/1ps
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] Aselect,
  input  logic [31:0] Bselect,
  input  logic [31:0] Dselect,
  input  logic        Imm,
  input  logic        LW,
  input  logic        SW,
  output logic        stall,
  output logic        bubble,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic [15:0] stall_cnt
);
  localparam logic [31:0] NO_R0 = ~32'h1;

  logic [31:0] s1_dst, s2_dst, s3_dst;
  logic        s1_lw;
  logic [15:0] stall_cnt_q;
  logic [31:0] dst_in;
  logic        a_use, b_use;
  logic        m1a, m2a, m3a, m1b, m2b, m3b;

  // Newest producer wins; a load still in execute cannot forward yet.
  function automatic logic [1:0] fwd_sel(input logic used, input logic m1, input logic m2,
                                         input logic m3, input logic lw1, input logic stl);
    if (stl || !used)   fwd_sel = 2'b00;
    else if (m1 && !lw1) fwd_sel = 2'b01;
    else if (m2)         fwd_sel = 2'b10;
    else if (m3)         fwd_sel = 2'b11;
    else                 fwd_sel = 2'b00;
  endfunction

  always_comb begin
    // r0 and stores never write a register, so they never create a hazard.
    dst_in = (valid_in && !SW) ? (Dselect & NO_R0) : 32'h0;
    a_use  = valid_in;
    b_use  = valid_in & (~Imm | SW);
    m1a    = |(Aselect & s1_dst & NO_R0);
    m2a    = |(Aselect & s2_dst & NO_R0);
    m3a    = |(Aselect & s3_dst & NO_R0);
    m1b    = |(Bselect & s1_dst & NO_R0);
    m2b    = |(Bselect & s2_dst & NO_R0);
    m3b    = |(Bselect & s3_dst & NO_R0);
    stall  = s1_lw & ((a_use & m1a) | (b_use & m1b));
    bubble = stall;
    fwdA   = fwd_sel(a_use, m1a, m2a, m3a, s1_lw, stall);
    fwdB   = fwd_sel(b_use, m1b, m2b, m3b, s1_lw, stall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dst      <= 32'h0;
      s1_lw       <= 1'b0;
      s2_dst      <= 32'h0;
      s3_dst      <= 32'h0;
      stall_cnt_q <= 16'h0;
    end else begin
      s3_dst <= s2_dst;
      s2_dst <= s1_dst;
      s1_dst <= stall ? 32'h0 : dst_in;
      s1_lw  <= stall ? 1'b0  : (LW & valid_in);
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'h1;
    end
  end

  assign stall_cnt = stall_cnt_q;
endmodule
